// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debouncer and press/release/long-press pulse generator
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release,
   output logic       btn_long,
   output logic [1:0] btn_state
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   localparam logic [DW-1:0] DEB_ONE       = DW'(1);
   localparam logic [DW-1:0] DEB_MAX       = DW'(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] HOLD_ONE      = HW'(1);
   localparam logic [HW-1:0] HOLD_MAX      = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_PRE_MAX  = HW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t          state;
   logic            s1;
   logic            s2;
   logic [DW-1:0]   deb_cnt;
   logic [HW-1:0]   hold_cnt;

   assign btn_state = state;

   // Two-flop synchroniser; only s2 is trusted by the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // Debounce FSM with registered level and single-cycle event pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
         case (state)
            IDLE: begin
               if (s2) begin
                  state   <= PRESS_WAIT;
                  deb_cnt <= DEB_ONE;
               end else begin
                  deb_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s2) begin
                  // Bounce: drop back silently.
                  state   <= IDLE;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_MAX) begin
                  state     <= PRESSED;
                  btn_level <= 1'b1;
                  btn_press <= 1'b1;
                  hold_cnt  <= '0;
                  deb_cnt   <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_ONE;
               end
            end
            PRESSED: begin
               // Saturating hold timer; long pulse only on the step into saturation.
               if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
                  if (hold_cnt == HOLD_PRE_MAX) begin
                     btn_long <= 1'b1;
                  end
               end
               if (!s2) begin
                  state   <= RELEASE_WAIT;
                  deb_cnt <= DEB_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (s2) begin
                  // Release glitch: resume the hold without losing elapsed time.
                  state   <= PRESSED;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_MAX) begin
                  state       <= IDLE;
                  btn_level   <= 1'b0;
                  btn_release <= 1'b1;
                  hold_cnt    <= '0;
                  deb_cnt     <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               deb_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner
module tb_btn_conditioner;

   localparam int DEB  = 4;
   localparam int LONG = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_raw = 1'b0;
   logic       btn_level;
   logic       btn_press;
   logic       btn_release;
   logic       btn_long;
   logic [1:0] btn_state;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_press_seen = 0;
   int n_rel_seen = 0;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   ev_t q[$];

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES(LONG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_long(btn_long),
      .btn_state(btn_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic match(input int k);
      ev_t e;
      if (q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected no pulse", k, cyc);
      end else begin
         e = q.pop_front();
         chk("pulse_kind", k, e.kind);
         chk("pulse_cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT emits a pulse.
   always @(negedge clk) begin
      if (!reset) begin
         n_press_seen = 0;
         n_rel_seen   = 0;
      end else begin
         if (btn_press) begin
            n_press_seen++;
            match(0);
         end
         if (btn_release) begin
            n_rel_seen++;
            match(1);
         end
         if (btn_long) match(2);
         chk("press_release_excl", int'(btn_press & btn_release), 0);
         chk("level_invariant", n_press_seen - n_rel_seen, int'(btn_level));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int c;
      int d;
      int r;

      // Reset state
      tick(3);
      chk("rst_level", int'(btn_level), 0);
      chk("rst_press", int'(btn_press), 0);
      chk("rst_release", int'(btn_release), 0);
      chk("rst_long", int'(btn_long), 0);
      chk("rst_state", int'(btn_state), 0);
      reset = 1'b1;
      tick(3);

      // Clean press, long hold
      c = cyc;
      btn_raw = 1'b1;
      q.push_back('{0, c + 7});
      q.push_back('{2, c + 27});
      tick(2);
      chk("press_state_c2", int'(btn_state), 0);
      tick(1);
      chk("press_state_c3", int'(btn_state), 1);
      tick(3);
      chk("press_state_c6", int'(btn_state), 1);
      chk("press_level_c6", int'(btn_level), 0);
      tick(1);
      chk("press_state_c7", int'(btn_state), 2);
      chk("press_level_c7", int'(btn_level), 1);
      tick(1);
      chk("press_pulse_gone", int'(btn_press), 0);
      tick(32);

      // Release glitch
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(1);
      chk("glitch_state_rw", int'(btn_state), 3);
      tick(4);
      chk("glitch_state_back", int'(btn_state), 2);
      chk("glitch_level", int'(btn_level), 1);

      // Real release
      d = cyc;
      btn_raw = 1'b0;
      q.push_back('{1, d + 7});
      tick(6);
      chk("rel_state_d6", int'(btn_state), 3);
      chk("rel_level_d6", int'(btn_level), 1);
      tick(1);
      chk("rel_state_d7", int'(btn_state), 0);
      chk("rel_level_d7", int'(btn_level), 0);
      tick(5);

      // Bounce rejection
      repeat (5) begin
         btn_raw = 1'b1;
         tick(3);
         btn_raw = 1'b0;
         tick(2);
      end
      tick(10);
      chk("bounce_state", int'(btn_state), 0);
      chk("bounce_level", int'(btn_level), 0);

      // Short press
      c = cyc;
      btn_raw = 1'b1;
      q.push_back('{0, c + 7});
      tick(10);
      btn_raw = 1'b0;
      q.push_back('{1, c + 17});
      tick(12);
      chk("short_state", int'(btn_state), 0);
      chk("short_level", int'(btn_level), 0);
      chk("short_hold_cnt", int'(dut.hold_cnt), 0);

      // Reset while pressed, button still held at reset release
      c = cyc;
      btn_raw = 1'b1;
      q.push_back('{0, c + 7});
      tick(12);
      chk("midrst_pre_state", int'(btn_state), 2);
      reset = 1'b0;
      #1;
      chk("midrst_level", int'(btn_level), 0);
      chk("midrst_state", int'(btn_state), 0);
      chk("midrst_release", int'(btn_release), 0);
      tick(3);
      r = cyc;
      reset = 1'b1;
      q.push_back('{0, r + 7});
      tick(6);
      chk("rerel_level_r6", int'(btn_level), 0);
      tick(1);
      chk("rerel_level_r7", int'(btn_level), 1);
      d = cyc;
      btn_raw = 1'b0;
      q.push_back('{1, d + 7});
      tick(10);

      // Drain
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         tick(1);
      end
      chk("queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
